// File: rtl/fifo_rr_arbiter_pkg.sv
// rtl/fifo_rr_arbiter_pkg.sv - shared widths, grant type and round-robin search for the FIFO arbiter
package fifo_rr_arbiter_pkg;

  localparam int DATA_BITS = 10;
  localparam int NUM_IN    = 4;
  localparam int SEL_BITS  = 2;
  localparam int CNT_BITS  = 8;

  typedef struct packed {
    logic                valid;
    logic [SEL_BITS-1:0] idx;
  } grant_t;

  // First requester found searching ptr+1, ptr+2, ... modulo NUM_IN.
  // Walks the candidates from farthest to nearest so the nearest one wins
  // without needing an early exit.
  function automatic grant_t rr_search(input logic [NUM_IN-1:0] req,
                                       input logic [SEL_BITS-1:0] ptr);
    grant_t g;
    int     cand;
    g = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_IN;
      if (req[cand]) begin
        g.valid = 1'b1;
        g.idx   = SEL_BITS'(cand);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// rtl/fifo_rr_arbiter_if.sv - upstream pop and downstream push signals of the FIFO arbiter
interface fifo_rr_arbiter_if import fifo_rr_arbiter_pkg::*; ();

  logic [NUM_IN-1:0]           fifo_empty_in;
  logic [NUM_IN*DATA_BITS-1:0] fifo_data_in;
  logic [NUM_IN-1:0]           fifo_read_out;
  logic                        down_almost_full_in;
  logic                        down_full_in;
  logic [DATA_BITS-1:0]        data_out;
  logic                        push_out;

  // Surroundings: upstream FIFOs and downstream FIFO flags
  modport master (
    output fifo_empty_in, fifo_data_in, down_almost_full_in, down_full_in,
    input  fifo_read_out, data_out, push_out
  );

  // The arbiter itself
  modport slave (
    input  fifo_empty_in, fifo_data_in, down_almost_full_in, down_full_in,
    output fifo_read_out, data_out, push_out
  );

endinterface

// File: rtl/fifo_rr_arbiter_pick.sv
// rtl/fifo_rr_arbiter_pick.sv - combinational round-robin pick: (req, ptr) -> (grant, grant_v)
module fifo_rr_pick import fifo_rr_arbiter_pkg::*; (
  input  logic [NUM_IN-1:0]   req,
  input  logic [SEL_BITS-1:0] ptr,
  output logic [SEL_BITS-1:0] grant,
  output logic                grant_v
);

  grant_t g;

  assign g       = rr_search(req, ptr);
  assign grant   = g.idx;
  assign grant_v = g.valid;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin merge of NUM_IN FIFOs into one stream; ARB_COUNT_EN adds per-input word counters
module fifo_rr_arbiter import fifo_rr_arbiter_pkg::*; (
  input  logic                     clk,
  input  logic                     reset,
  fifo_rr_arbiter_if.slave         bus,
  output logic                     idle_out,
  output logic                     error_arb_out
`ifdef ARB_COUNT_EN
  ,
  output logic [NUM_IN*CNT_BITS-1:0] count_out
`endif
);

  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS-1:0] grant;
  logic                grant_v;
  logic [NUM_IN-1:0]   req;
  logic                pop_en;
  logic                pop_v1;
  logic [SEL_BITS-1:0] src1;

  assign req = ~bus.fifo_empty_in;

  fifo_rr_pick u_pick (
    .req     (req),
    .ptr     (ptr),
    .grant   (grant),
    .grant_v (grant_v)
  );

  // Pops are held off while reset is low so nothing leaves the FIFOs unseen
  assign pop_en = grant_v & ~bus.down_almost_full_in & reset;

  // One-hot pop strobe for the granted FIFO
  always_comb begin
    bus.fifo_read_out = '0;
    if (pop_en) bus.fifo_read_out[grant] = 1'b1;
  end

  // Pointer, pop/index pipeline and registered push to the downstream FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= SEL_BITS'(NUM_IN - 1);
      pop_v1       <= 1'b0;
      src1         <= '0;
      bus.push_out <= 1'b0;
      bus.data_out <= '0;
    end else begin
      if (pop_en) ptr <= grant;
      pop_v1       <= pop_en;
      src1         <= grant;
      bus.push_out <= pop_v1;
      if (pop_v1) bus.data_out <= bus.fifo_data_in[int'(src1)*DATA_BITS +: DATA_BITS];
    end
  end

  // Sticky flag: a push landed on a full downstream FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) error_arb_out <= 1'b0;
    else if (bus.push_out && bus.down_full_in) error_arb_out <= 1'b1;
  end

  assign idle_out = ~|bus.fifo_read_out & ~pop_v1 & ~bus.push_out;

`ifdef ARB_COUNT_EN
  logic [CNT_BITS-1:0] cnt [NUM_IN];

  // Saturating count of words forwarded per source, updated with the push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else if (pop_v1 && (cnt[src1] != '1)) begin
      cnt[src1] <= cnt[src1] + CNT_BITS'(1);
    end
  end

  // Flatten the counters onto the output bus
  always_comb begin
    count_out = '0;
    for (int i = 0; i < NUM_IN; i++) count_out[i*CNT_BITS +: CNT_BITS] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - randomized self-checking bench for fifo_rr_arbiter against a queue-based model
module tb_fifo_rr_arbiter;
  import fifo_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic idle_out;
  logic error_arb_out;
`ifdef ARB_COUNT_EN
  logic [NUM_IN*CNT_BITS-1:0] count_out;
`endif

  always #5 clk = ~clk;

  fifo_rr_arbiter_if bus ();

  fifo_rr_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .idle_out      (idle_out),
    .error_arb_out (error_arb_out)
`ifdef ARB_COUNT_EN
    ,
    .count_out     (count_out)
`endif
  );

  // Upstream FIFOs: contents plus the registered read-data port
  logic [DATA_BITS-1:0] fq [NUM_IN][$];
  logic [DATA_BITS-1:0] dout [NUM_IN];

  // Reference model state
  int                   m_ptr;
  bit                   sched_v [int];
  logic [DATA_BITS-1:0] sched_d [int];
  int                   sched_s [int];
  bit                   m_err;
  logic [DATA_BITS-1:0] m_last;
  int                   m_cnt [NUM_IN];
  int                   cyc;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_IN; i++) begin
      bus.fifo_empty_in[i] = (fq[i].size() == 0);
      bus.fifo_data_in[i*DATA_BITS +: DATA_BITS] = dout[i];
    end
  endtask

  task automatic put_word(input int i, input logic [DATA_BITS-1:0] w);
    fq[i].push_back(w);
    drive_inputs();
  endtask

  task automatic model_clear();
    m_ptr = NUM_IN - 1;
    sched_v.delete();
    sched_d.delete();
    sched_s.delete();
    m_err  = 1'b0;
    m_last = '0;
    for (int i = 0; i < NUM_IN; i++) m_cnt[i] = 0;
  endtask

  // One clock: compare at the falling edge, then apply FIFO pops just after the rising edge
  task automatic cycle();
    int                g;
    bit                push_now;
    logic [NUM_IN-1:0] exp_rd;
    g = -1;
    @(negedge clk);
    if (!reset) begin
      model_clear();
      check("rst_fifo_read", bus.fifo_read_out, 0);
      check("rst_push", bus.push_out, 0);
      check("rst_data", bus.data_out, 0);
      check("rst_error", error_arb_out, 0);
      check("rst_idle", idle_out, 1);
`ifdef ARB_COUNT_EN
      check("rst_count", count_out, 0);
`endif
    end else begin
      exp_rd = '0;
      if (!bus.down_almost_full_in) begin
        for (int k = 1; k <= NUM_IN; k++) begin
          int c;
          c = (m_ptr + k) % NUM_IN;
          if (g < 0 && fq[c].size() > 0) g = c;
        end
      end
      if (g >= 0) exp_rd[g] = 1'b1;
      check("fifo_read", bus.fifo_read_out, exp_rd);
      push_now = sched_v.exists(cyc);
      check("push", bus.push_out, push_now);
      if (push_now) begin
        m_last = sched_d[cyc];
        if (m_cnt[sched_s[cyc]] < (1 << CNT_BITS) - 1) m_cnt[sched_s[cyc]]++;
      end
      check("data", bus.data_out, m_last);
      check("error", error_arb_out, m_err);
      check("idle", idle_out, (g < 0) && !sched_v.exists(cyc + 1) && !push_now);
`ifdef ARB_COUNT_EN
      for (int i = 0; i < NUM_IN; i++)
        check("count", count_out[i*CNT_BITS +: CNT_BITS], m_cnt[i]);
`endif
      if (push_now && bus.down_full_in) m_err = 1'b1;
      if (g >= 0) begin
        m_ptr = g;
        sched_v[cyc + 2] = 1'b1;
        sched_d[cyc + 2] = fq[g][0];
        sched_s[cyc + 2] = g;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    if (g >= 0) dout[g] = fq[g].pop_front();
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b0;
    run(n);
    reset = 1'b1;
  endtask

  initial begin
    cyc = 0;
    model_clear();
    for (int i = 0; i < NUM_IN; i++) dout[i] = '0;
    bus.down_almost_full_in = 1'b0;
    bus.down_full_in        = 1'b0;
    drive_inputs();

    // Reset with every FIFO holding words 0x101..0x108 laid out for RR order
    for (int i = 0; i < NUM_IN; i++) begin
      put_word(i, DATA_BITS'(32'h101 + i));
      put_word(i, DATA_BITS'(32'h105 + i));
    end
    run(3);
    reset = 1'b1;
    run(12);

    // Single busy FIFO, then a second one joins
    for (int w = 0; w < 3; w++) put_word(2, DATA_BITS'(32'h2a0 + w));
    run(6);
    put_word(1, DATA_BITS'(10'h3c1));
    put_word(2, DATA_BITS'(10'h3c2));
    run(6);

    // Almost-full raised mid-stream, then dropped
    for (int i = 0; i < NUM_IN; i++)
      for (int w = 0; w < 3; w++) put_word(i, DATA_BITS'(32'h040 + 16 * i + w));
    run(3);
    bus.down_almost_full_in = 1'b1;
    run(4);
    bus.down_almost_full_in = 1'b0;
    run(14);

    // Push into a full downstream FIFO sets the sticky error until reset
    put_word(3, DATA_BITS'(10'h155));
    put_word(3, DATA_BITS'(10'h2aa));
    bus.down_full_in = 1'b1;
    run(6);
    bus.down_full_in = 1'b0;
    run(3);
    pulse_reset(2);
    run(2);

    // Randomized traffic with flow-control noise
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0)
        put_word(int'($urandom_range(0, NUM_IN - 1)), DATA_BITS'($urandom));
      bus.down_almost_full_in = ($urandom_range(0, 4) == 0);
      bus.down_full_in        = ($urandom_range(0, 30) == 0);
      drive_inputs();
      cycle();
      if (n == 200) pulse_reset(2);
    end
    bus.down_almost_full_in = 1'b0;
    bus.down_full_in        = 1'b0;
    run(60);

`ifdef ARB_COUNT_EN
    // Counter saturation on FIFO0, then reset in the middle of a burst
    pulse_reset(2);
    for (int w = 0; w < 300; w++) put_word(0, DATA_BITS'(w));
    run(305);
    check("count0_sat", count_out[CNT_BITS-1:0], 255);
    for (int w = 0; w < 20; w++) put_word(0, DATA_BITS'(w));
    run(5);
    pulse_reset(2);
    run(25);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
